// File: rtl/port_response_router.sv
// -----------------------------------------------------------------------------
// port_response_router
//
// Return path for the round-robin port arbiter. Every granted request pushes
// its port index into a tag FIFO in issue order. The shared resource returns
// responses strictly in order, so each accepted response is paired with the
// FIFO head and steered back to the port that issued it through a single
// registered output stage.
//
// Optional feature (compile-time macro RESP_ORPHAN_CHECK_EN):
//   Adds OrphanError (sticky) and OrphanCount (8-bit saturating), which flag
//   responses that arrive while no request is outstanding.
//
// Ports:
//   clk, async_rst         clock, asynchronous active-high reset
//   clk_en                 global clock enable; low freezes all state
//   IssueValid/IssuePort   granted request and its port index (push side)
//   IssueReady             tag FIFO not full
//   RespValid/RespData     in-order response from the shared resource
//   RespReady              response accepted this cycle
//   PortRespValid          one-hot valid toward the destination port
//   PortRespData           payload bus shared by all ports
//   PortRespReady          per-port accept; only the held port's bit matters
//   OutstandingCount       number of tags in the FIFO
//   Empty, Full            FIFO status
//   OrphanError            (macro only) sticky orphan-response flag
//   OrphanCount            (macro only) saturating orphan-response count
//
// Handshake semantics (all interfaces): a transfer happens on a rising clk
// edge with clk_en high when both valid and ready are high. Ready never
// depends on valid on the same interface. A producer holds valid and its
// payload stable until the transfer completes; the issue side is pushed
// only while IssueReady is high, the response side is accepted only while
// RespReady is high, and a held port response stays on PortRespValid /
// PortRespData until PortRespReady of that port is seen.
// -----------------------------------------------------------------------------
module port_response_router #(
    parameter int PORTCOUNT      = 4,
    parameter int PORTADDRWIDTH  = 2,
    parameter int DATAWIDTH      = 32,
    parameter int DEPTH          = 8,
    parameter int DEPTHADDRWIDTH = 3
) (
    input  logic                      clk,
    input  logic                      async_rst,
    input  logic                      clk_en,

    input  logic                      IssueValid,
    input  logic [PORTADDRWIDTH-1:0]  IssuePort,
    output logic                      IssueReady,

    input  logic                      RespValid,
    input  logic [DATAWIDTH-1:0]      RespData,
    output logic                      RespReady,

    output logic [PORTCOUNT-1:0]      PortRespValid,
    output logic [DATAWIDTH-1:0]      PortRespData,
    input  logic [PORTCOUNT-1:0]      PortRespReady,

    output logic [DEPTHADDRWIDTH:0]   OutstandingCount,
    output logic                      Empty,
    output logic                      Full
`ifdef RESP_ORPHAN_CHECK_EN
    ,
    output logic                      OrphanError,
    output logic [7:0]                OrphanCount
`endif
);

    // Sized copies of the integer parameters so comparisons stay width-exact.
    localparam logic [DEPTHADDRWIDTH:0] DepthCount = DEPTH[DEPTHADDRWIDTH:0];
    localparam logic [PORTADDRWIDTH:0]  PortLimit  = PORTCOUNT[PORTADDRWIDTH:0];

    // -------------------------------------------------------------------------
    // Tag FIFO storage and pointers
    // -------------------------------------------------------------------------
    logic [PORTADDRWIDTH-1:0]  tagMem [DEPTH];
    logic [DEPTHADDRWIDTH-1:0] wrPtr;
    logic [DEPTHADDRWIDTH-1:0] rdPtr;
    logic [DEPTHADDRWIDTH:0]   count;

    // -------------------------------------------------------------------------
    // Output stage registers
    // -------------------------------------------------------------------------
    logic                      outValid;
    logic [PORTADDRWIDTH-1:0]  outPort;
    logic [DATAWIDTH-1:0]      outData;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic                      push;
    logic                      pop;
    logic                      outPortInRange;
    logic                      heldPortReady;
    logic                      stageFree;

    assign Empty            = (count == '0);
    assign Full             = (count == DepthCount);
    assign OutstandingCount = count;

    // IssueReady looks only at Full: a pop in the same cycle does not open a
    // slot early, which keeps the arbiter-facing ready free of response timing.
    assign IssueReady = !Full;
    assign push       = clk_en && IssueValid && !Full;

    // A stored index can exceed the port count when PORTCOUNT is not a power
    // of two. Such an entry drives no valid and needs no ready to leave.
    assign outPortInRange = ({1'b0, outPort} < PortLimit);

    // Select the ready bit of the held port without an out-of-range index.
    always_comb begin
        heldPortReady = 1'b0;
        for (int i = 0; i < PORTCOUNT; i++) begin
            if (outPort == PORTADDRWIDTH'(i)) begin
                heldPortReady = PortRespReady[i];
            end
        end
    end

    // The stage can take a new response if it is idle or is draining now.
    assign stageFree = !outValid || !outPortInRange || heldPortReady;

    // No empty-bypass: a response is only taken against a tag that is already
    // in the FIFO, so a same-cycle issue on an empty FIFO cannot be matched.
    assign RespReady = clk_en && !Empty && stageFree;
    assign pop       = RespReady && RespValid;

    // -------------------------------------------------------------------------
    // Tag storage (no reset needed; pointers/count define validity)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            tagMem[wrPtr] <= IssuePort;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count and output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            outValid <= 1'b0;
            outPort  <= '0;
            outData  <= '0;
        end else if (clk_en) begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Reload has priority over drain, giving back-to-back delivery.
            if (pop) begin
                outValid <= 1'b1;
                outPort  <= tagMem[rdPtr];
                outData  <= RespData;
            end else if (outValid && stageFree) begin
                outValid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Port-facing outputs: one-hot decode of the held port index
    // -------------------------------------------------------------------------
    always_comb begin
        PortRespValid = '0;
        for (int i = 0; i < PORTCOUNT; i++) begin
            PortRespValid[i] = outValid && (outPort == PORTADDRWIDTH'(i));
        end
    end

    assign PortRespData = outData;

`ifdef RESP_ORPHAN_CHECK_EN
    // -------------------------------------------------------------------------
    // Orphan response detection: a response with nothing outstanding
    // -------------------------------------------------------------------------
    logic orphanHit;

    assign orphanHit = clk_en && RespValid && Empty;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            OrphanError <= 1'b0;
            OrphanCount <= '0;
        end else if (orphanHit) begin
            OrphanError <= 1'b1;
            if (OrphanCount != 8'hFF) begin
                OrphanCount <= OrphanCount + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_port_response_router.sv
// -----------------------------------------------------------------------------
// tb_port_response_router
//
// Directed bench for port_response_router at default parameters. Stimulus is
// a linear sequence of steps; expected values are hand-computed constants,
// plus an expected queue for the randomized in-order delivery run.
// Define RESP_ORPHAN_CHECK_EN for both files to include the orphan steps.
// -----------------------------------------------------------------------------
module tb_port_response_router;

    localparam int PORTCOUNT      = 4;
    localparam int PORTADDRWIDTH  = 2;
    localparam int DATAWIDTH      = 32;
    localparam int DEPTH          = 8;
    localparam int DEPTHADDRWIDTH = 3;
    localparam int ExpW           = PORTCOUNT + DATAWIDTH;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic                      clk;
    logic                      async_rst;
    logic                      clk_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic                      IssueValid;
    logic [PORTADDRWIDTH-1:0]  IssuePort;
    logic                      IssueReady;
    logic                      RespValid;
    logic [DATAWIDTH-1:0]      RespData;
    logic                      RespReady;
    logic [PORTCOUNT-1:0]      PortRespValid;
    logic [DATAWIDTH-1:0]      PortRespData;
    logic [PORTCOUNT-1:0]      PortRespReady;
    logic [DEPTHADDRWIDTH:0]   OutstandingCount;
    logic                      Empty;
    logic                      Full;
`ifdef RESP_ORPHAN_CHECK_EN
    logic                      OrphanError;
    logic [7:0]                OrphanCount;
`endif

    port_response_router #(
        .PORTCOUNT      (PORTCOUNT),
        .PORTADDRWIDTH  (PORTADDRWIDTH),
        .DATAWIDTH      (DATAWIDTH),
        .DEPTH          (DEPTH),
        .DEPTHADDRWIDTH (DEPTHADDRWIDTH)
    ) dut (
        .clk              (clk),
        .async_rst        (async_rst),
        .clk_en           (clk_en),
        .IssueValid       (IssueValid),
        .IssuePort        (IssuePort),
        .IssueReady       (IssueReady),
        .RespValid        (RespValid),
        .RespData         (RespData),
        .RespReady        (RespReady),
        .PortRespValid    (PortRespValid),
        .PortRespData     (PortRespData),
        .PortRespReady    (PortRespReady),
        .OutstandingCount (OutstandingCount),
        .Empty            (Empty),
        .Full             (Full)
`ifdef RESP_ORPHAN_CHECK_EN
        ,
        .OrphanError      (OrphanError),
        .OrphanCount      (OrphanCount)
`endif
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int passed = 0;
    int total  = 0;
    logic [ExpW-1:0]      exp_q[$];
    logic [DATAWIDTH-1:0] drv_q[$];

    // -------------------------------------------------------------------------
    // Driver / checker tasks
    // -------------------------------------------------------------------------
    // Advance one clock and settle 1ns past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [PORTADDRWIDTH-1:0] p);
        IssueValid = 1'b1;
        IssuePort  = p;
        tick();
        IssueValid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [ExpW-1:0]      e;
        logic [DATAWIDTH-1:0] d;
        logic [PORTCOUNT-1:0] oh;
        int                   p;

        async_rst     = 1'b1;
        clk_en        = 1'b1;
        IssueValid    = 1'b0;
        IssuePort     = '0;
        RespValid     = 1'b0;
        RespData      = '0;
        PortRespReady = '0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_count", 64'(OutstandingCount), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_prv", 64'(PortRespValid), 64'd0);
        chk("rst_prd", 64'(PortRespData), 64'd0);
        chk("rst_issue_ready", 64'(IssueReady), 64'd1);
        async_rst = 1'b0;
        #1;
        chk("rst_resp_ready", 64'(RespReady), 64'd0);

        // ---- clk_en low freezes the FIFO ----
        clk_en = 1'b0;
        issue(2'd1);
        chk("cen_no_push", 64'(OutstandingCount), 64'd0);
        clk_en = 1'b1;

        // ---- basic steering: ports 2,0,3 with data A,B,C ----
        PortRespReady = 4'hF;
        issue(2'd2);
        issue(2'd0);
        issue(2'd3);
        chk("t1_count3", 64'(OutstandingCount), 64'd3);
        RespValid = 1'b1;
        RespData  = 32'hA;
        #1;
        chk("t1_resp_ready", 64'(RespReady), 64'd1);
        tick();
        chk("t1_prv_a", 64'(PortRespValid), 64'b0100);
        chk("t1_prd_a", 64'(PortRespData), 64'hA);
        RespData = 32'hB;
        tick();
        chk("t1_prv_b", 64'(PortRespValid), 64'b0001);
        chk("t1_prd_b", 64'(PortRespData), 64'hB);
        RespData = 32'hC;
        tick();
        chk("t1_prv_c", 64'(PortRespValid), 64'b1000);
        chk("t1_prd_c", 64'(PortRespData), 64'hC);
        chk("t1_empty", 64'(Empty), 64'd1);
        RespValid = 1'b0;
        tick();
        chk("t1_drained", 64'(PortRespValid), 64'd0);

        // ---- fill to DEPTH ----
        IssueValid = 1'b1;
        IssuePort  = 2'd1;
        repeat (8) tick();
        chk("t2_count8", 64'(OutstandingCount), 64'd8);
        chk("t2_full", 64'(Full), 64'd1);
        chk("t2_issue_ready0", 64'(IssueReady), 64'd0);
        tick();
        chk("t2_ninth_ignored", 64'(OutstandingCount), 64'd8);
        RespValid = 1'b1;
        RespData  = 32'h11;
        #1;
        chk("t2_ready_while_full", 64'(RespReady), 64'd1);
        chk("t2_no_full_bypass", 64'(IssueReady), 64'd0);
        tick();
        chk("t2_count7", 64'(OutstandingCount), 64'd7);
        chk("t2_prv_port1", 64'(PortRespValid), 64'b0010);
        RespValid = 1'b0;
        chk("t2_issue_ready1", 64'(IssueReady), 64'd1);
        tick();
        chk("t2_refill8", 64'(OutstandingCount), 64'd8);
        IssueValid = 1'b0;
        RespValid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RespData = 32'h20 + 32'(i);
            tick();
        end
        RespValid = 1'b0;
        chk("t2_drain_count", 64'(OutstandingCount), 64'd0);
        chk("t2_last_data", 64'(PortRespData), 64'h27);
        tick();

        // ---- backpressure on port 3 ----
        issue(2'd3);
        issue(2'd2);
        PortRespReady = 4'b0000;
        RespValid     = 1'b1;
        RespData      = 32'h55;
        tick();
        chk("t3_prv_p3", 64'(PortRespValid), 64'b1000);
        chk("t3_prd_55", 64'(PortRespData), 64'h55);
        RespData = 32'h66;
        #1;
        chk("t3_stall_ready", 64'(RespReady), 64'd0);
        tick();
        chk("t3_hold_data", 64'(PortRespData), 64'h55);
        chk("t3_hold_count", 64'(OutstandingCount), 64'd1);
        PortRespReady = 4'b0010;
        #1;
        chk("t3_other_ready_ignored", 64'(RespReady), 64'd0);
        tick();
        chk("t3_hold_prv", 64'(PortRespValid), 64'b1000);
        clk_en        = 1'b0;
        PortRespReady = 4'b1000;
        #1;
        chk("t3_cen_ready0", 64'(RespReady), 64'd0);
        tick();
        chk("t3_cen_hold_data", 64'(PortRespData), 64'h55);
        clk_en = 1'b1;
        #1;
        chk("t3_release_ready", 64'(RespReady), 64'd1);
        tick();
        chk("t3_reload_prv", 64'(PortRespValid), 64'b0100);
        chk("t3_reload_prd", 64'(PortRespData), 64'h66);
        chk("t3_count0", 64'(OutstandingCount), 64'd0);
        RespValid     = 1'b0;
        PortRespReady = 4'hF;
        tick();

        // ---- no empty-bypass ----
        IssueValid = 1'b1;
        IssuePort  = 2'd0;
        RespValid  = 1'b1;
        RespData   = 32'h77;
        #1;
        chk("t4_no_bypass", 64'(RespReady), 64'd0);
        tick();
        IssueValid = 1'b0;
        chk("t4_push_only", 64'(OutstandingCount), 64'd1);
        chk("t4_no_out", 64'(PortRespValid), 64'd0);
        #1;
        chk("t4_next_ready", 64'(RespReady), 64'd1);
        tick();
        RespValid = 1'b0;
        chk("t4_prv", 64'(PortRespValid), 64'b0001);
        chk("t4_prd", 64'(PortRespData), 64'h77);
        tick();

        // ---- 20 pipelined issue/response pairs, random ports (wraps pointers) ----
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin
                p  = int'($urandom_range(0, PORTCOUNT - 1));
                d  = $urandom;
                oh = PORTCOUNT'(1 << p);
                IssueValid = 1'b1;
                IssuePort  = PORTADDRWIDTH'(p);
                drv_q.push_back(d);
                exp_q.push_back({oh, d});
            end else begin
                IssueValid = 1'b0;
            end
            if (k > 0) begin
                RespValid = 1'b1;
                RespData  = drv_q.pop_front();
            end else begin
                RespValid = 1'b0;
            end
            tick();
            if (k > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("t5_prv_%0d", k), 64'(PortRespValid), 64'(e[ExpW-1:DATAWIDTH]));
                chk($sformatf("t5_prd_%0d", k), 64'(PortRespData), 64'(e[DATAWIDTH-1:0]));
            end
        end
        RespValid = 1'b0;
        chk("t5_count0", 64'(OutstandingCount), 64'd0);
        chk("t5_empty", 64'(Empty), 64'd1);
        tick();

        // ---- asynchronous reset mid-stream ----
        PortRespReady = 4'b0000;
        issue(2'd1);
        issue(2'd2);
        issue(2'd3);
        issue(2'd0);
        RespValid = 1'b1;
        RespData  = 32'h99;
        tick();
        RespValid = 1'b0;
        chk("t6_held", 64'(PortRespValid), 64'b0010);
        chk("t6_count3", 64'(OutstandingCount), 64'd3);
        #2;
        async_rst = 1'b1;
        #1;
        chk("t6_async_prv", 64'(PortRespValid), 64'd0);
        chk("t6_async_prd", 64'(PortRespData), 64'd0);
        chk("t6_async_count", 64'(OutstandingCount), 64'd0);
        chk("t6_async_empty", 64'(Empty), 64'd1);
        tick();
        async_rst     = 1'b0;
        PortRespReady = 4'hF;
        RespValid     = 1'b1;
        #1;
        chk("t6_post_ready", 64'(RespReady), 64'd0);
        tick();
        RespValid = 1'b0;
        chk("t6_no_delivery", 64'(PortRespValid), 64'd0);

`ifdef RESP_ORPHAN_CHECK_EN
        // ---- orphan detection ----
        async_rst = 1'b1;
        tick();
        async_rst = 1'b0;
        chk("t7_err_rst", 64'(OrphanError), 64'd0);
        chk("t7_cnt_rst", 64'(OrphanCount), 64'd0);
        RespValid = 1'b1;
        repeat (3) tick();
        RespValid = 1'b0;
        chk("t7_err_set", 64'(OrphanError), 64'd1);
        chk("t7_cnt3", 64'(OrphanCount), 64'd3);
        issue(2'd0);
        tick();
        chk("t7_err_sticky", 64'(OrphanError), 64'd1);
        chk("t7_cnt_hold", 64'(OrphanCount), 64'd3);
        async_rst = 1'b1;
        #1;
        chk("t7_err_clear", 64'(OrphanError), 64'd0);
        chk("t7_cnt_clear", 64'(OrphanCount), 64'd0);
        tick();
        async_rst = 1'b0;
`endif

        // ---- final report ----
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
